// File: rtl/note_tone_gen.sv
// Runtime-programmable square-wave tone generator: a per-note table of half-period
// terminal counts, an octave shift, and a gated start/stop that always ends low.
module note_tone_gen #(
    parameter int NUM_NOTES = 8,
    parameter int SEL_WIDTH = 3,
    parameter int CNT_WIDTH = 19,
    parameter logic [NUM_NOTES*CNT_WIDTH-1:0] DEFAULT_TABLE = {
        19'd95556, 19'd101238, 19'd113635, 19'd127550,
        19'd143171, 19'd151684, 19'd170265, 19'd191109
    }
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 note_en_i,
    input  logic [SEL_WIDTH-1:0] note_sel_i,
    input  logic [1:0]           octave_i,
    input  logic                 cfg_we_i,
    input  logic [SEL_WIDTH-1:0] cfg_addr_i,
    input  logic [CNT_WIDTH-1:0] cfg_data_i,
    output logic                 tone_out_o,
    output logic                 playing_o,
    output logic [SEL_WIDTH-1:0] cur_note_o
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_NOTES - 1);
    localparam logic [CNT_WIDTH:0]   ONE_W    = 1;
    localparam logic [CNT_WIDTH-1:0] ONE_C    = 1;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   term_q, term_d;
    logic [SEL_WIDTH-1:0]   curNote_q, curNote_d;
    logic                   tone_q, tone_d;
    logic [CNT_WIDTH-1:0]   table_q [NUM_NOTES];

    logic [SEL_WIDTH-1:0]   selClamped;
    logic [CNT_WIDTH:0]     halfPlusOne;
    logic [CNT_WIDTH:0]     shifted;
    logic [CNT_WIDTH:0]     shiftedMinusOne;
    logic [CNT_WIDTH-1:0]   effTerm;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                table_q[i] <= DEFAULT_TABLE[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end else if (cfg_we_i && (cfg_addr_i <= LAST_IDX)) begin
            table_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    // Half-period is T+1 clocks; the octave shift acts on that length, not on T.
    always_comb begin
        selClamped      = (note_sel_i > LAST_IDX) ? LAST_IDX : note_sel_i;
        halfPlusOne     = {1'b0, table_q[selClamped]} + ONE_W;
        shifted         = halfPlusOne >> octave_i;
        shiftedMinusOne = shifted - ONE_W;
        effTerm         = (shifted == '0) ? '0 : shiftedMinusOne[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            term_q    <= '0;
            curNote_q <= '0;
            tone_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            term_q    <= term_d;
            curNote_q <= curNote_d;
            tone_q    <= tone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        term_d    = term_q;
        curNote_d = curNote_q;
        tone_d    = tone_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tone_d = 1'b0;
                if (note_en_i) begin
                    term_d    = effTerm;
                    curNote_d = selClamped;
                    tone_d    = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == term_q) begin
                    cnt_d     = '0;
                    tone_d    = 1'b0;
                    term_d    = effTerm;
                    curNote_d = selClamped;
                    state_d   = LOW;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            LOW: begin
                // The gate is only consulted here, so the tone always stops on a full period.
                if (cnt_q == term_q) begin
                    cnt_d = '0;
                    if (note_en_i) begin
                        tone_d    = 1'b1;
                        term_d    = effTerm;
                        curNote_d = selClamped;
                        state_d   = HIGH;
                    end else begin
                        tone_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

    assign tone_out_o = tone_q;
    assign playing_o  = (state_q != IDLE);
    assign cur_note_o = curNote_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen using a small 6-note, 8-bit table so that every
// phase length can be counted cycle by cycle against hand-computed values.
module tb_note_tone_gen;

    localparam int NUM_NOTES = 6;
    localparam int SEL_WIDTH = 3;
    localparam int CNT_WIDTH = 8;
    // entries 0..5 = 2, 4, 7, 1, 3, 5
    localparam logic [NUM_NOTES*CNT_WIDTH-1:0] TABLE_INIT =
        {8'd5, 8'd3, 8'd1, 8'd7, 8'd4, 8'd2};

    logic                 clk;
    logic                 resetN;
    logic                 noteEn;
    logic [SEL_WIDTH-1:0] noteSel;
    logic [1:0]           octave;
    logic                 cfgWe;
    logic [SEL_WIDTH-1:0] cfgAddr;
    logic [CNT_WIDTH-1:0] cfgData;
    logic                 toneOut;
    logic                 playing;
    logic [SEL_WIDTH-1:0] curNote;

    int vectors  = 0;
    int failures = 0;
    int len;

    note_tone_gen #(
        .NUM_NOTES    (NUM_NOTES),
        .SEL_WIDTH    (SEL_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .DEFAULT_TABLE(TABLE_INIT)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (resetN),
        .note_en_i  (noteEn),
        .note_sel_i (noteSel),
        .octave_i   (octave),
        .cfg_we_i   (cfgWe),
        .cfg_addr_i (cfgAddr),
        .cfg_data_i (cfgData),
        .tone_out_o (toneOut),
        .playing_o  (playing),
        .cur_note_o (curNote)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [SEL_WIDTH-1:0] sel,
                                 input logic [1:0] oct);
        noteEn  = en;
        noteSel = sel;
        octave  = oct;
    endtask

    task automatic cfgWrite(input logic [SEL_WIDTH-1:0] addr, input logic [CNT_WIDTH-1:0] data);
        cfgWe   = 1'b1;
        cfgAddr = addr;
        cfgData = data;
        @(negedge clk);
        cfgWe   = 1'b0;
    endtask

    // Counts negedge samples at the given level while playing, bounded.
    task automatic measureRun(input logic level, output int n);
        n = 0;
        while (toneOut == level && playing && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        resetN = 1'b0;
        cfgWe = 1'b0; cfgAddr = '0; cfgData = '0;
        applyStimulus(1'b0, 3'd0, 2'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst_tone", int'(toneOut), 0);
        checkOutput("rst_playing", int'(playing), 0);
        checkOutput("rst_curnote", int'(curNote), 0);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_tone", int'(toneOut), 0);
        checkOutput("idle_playing", int'(playing), 0);

        applyStimulus(1'b1, 3'd1, 2'd0);
        @(negedge clk);
        checkOutput("start_tone", int'(toneOut), 1);
        checkOutput("start_playing", int'(playing), 1);
        checkOutput("start_curnote", int'(curNote), 1);
        measureRun(1'b1, len); checkOutput("n1_high", len, 5);
        measureRun(1'b0, len); checkOutput("n1_low", len, 5);

        @(negedge clk);
        applyStimulus(1'b1, 3'd0, 2'd0);
        measureRun(1'b1, len); checkOutput("sw_high_rest", len, 4);
        checkOutput("sw_curnote", int'(curNote), 0);
        measureRun(1'b0, len); checkOutput("sw_low", len, 3);
        measureRun(1'b1, len); checkOutput("sw_high2", len, 3);

        applyStimulus(1'b1, 3'd2, 2'd0);
        measureRun(1'b0, len); checkOutput("oct_pre_low", len, 3);
        measureRun(1'b1, len); checkOutput("oct0_high", len, 8);
        applyStimulus(1'b1, 3'd2, 2'd1);
        measureRun(1'b0, len); checkOutput("oct0_low", len, 8);
        measureRun(1'b1, len); checkOutput("oct1_high", len, 4);
        applyStimulus(1'b1, 3'd2, 2'd2);
        measureRun(1'b0, len); checkOutput("oct1_low", len, 4);
        measureRun(1'b1, len); checkOutput("oct2_high", len, 2);
        applyStimulus(1'b1, 3'd2, 2'd3);
        measureRun(1'b0, len); checkOutput("oct2_low", len, 2);
        measureRun(1'b1, len); checkOutput("oct3_high", len, 1);
        applyStimulus(1'b1, 3'd0, 2'd3);
        measureRun(1'b0, len); checkOutput("oct3_low", len, 1);
        measureRun(1'b1, len); checkOutput("zero_shift_high", len, 1);

        applyStimulus(1'b1, 3'd7, 2'd0);
        measureRun(1'b0, len); checkOutput("zero_shift_low", len, 1);
        checkOutput("clamp_curnote", int'(curNote), 5);
        measureRun(1'b1, len); checkOutput("clamp_high", len, 6);

        applyStimulus(1'b1, 3'd1, 2'd0);
        measureRun(1'b0, len); checkOutput("clamp_low", len, 6);
        @(negedge clk);
        applyStimulus(1'b0, 3'd1, 2'd0);
        measureRun(1'b1, len); checkOutput("gate_high_rest", len, 4);
        measureRun(1'b0, len); checkOutput("gate_low", len, 5);
        checkOutput("gate_stop_playing", int'(playing), 0);
        checkOutput("gate_stop_tone", int'(toneOut), 0);

        applyStimulus(1'b1, 3'd1, 2'd0);
        @(negedge clk);
        checkOutput("restart_tone", int'(toneOut), 1);
        measureRun(1'b1, len); checkOutput("restart_high", len, 5);
        applyStimulus(1'b0, 3'd1, 2'd0);
        repeat (4) @(negedge clk);
        checkOutput("reassert_low_playing", int'(playing), 1);
        checkOutput("reassert_low_tone", int'(toneOut), 0);
        applyStimulus(1'b1, 3'd1, 2'd0);
        @(negedge clk);
        checkOutput("reassert_tone", int'(toneOut), 1);
        measureRun(1'b1, len); checkOutput("reassert_high", len, 5);

        cfgWrite(3'd1, 8'd9);
        measureRun(1'b0, len); checkOutput("cfg_low_rest", len, 4);
        measureRun(1'b1, len); checkOutput("cfg_high_new", len, 10);
        measureRun(1'b0, len); checkOutput("cfg_low_new", len, 10);

        repeat (9) @(negedge clk);
        cfgWrite(3'd1, 8'd4);
        measureRun(1'b0, len); checkOutput("simul_low_old", len, 10);
        measureRun(1'b1, len); checkOutput("simul_high_new", len, 5);

        applyStimulus(1'b1, 3'd7, 2'd0);
        cfgWrite(3'd6, 8'd1);
        measureRun(1'b0, len); checkOutput("ignored_wr_low", len, 4);
        measureRun(1'b1, len); checkOutput("ignored_wr_high", len, 6);
        measureRun(1'b0, len); checkOutput("ignored_wr_low2", len, 6);

        @(negedge clk);
        resetN = 1'b0;
        applyStimulus(1'b1, 3'd1, 2'd0);
        @(negedge clk);
        checkOutput("midrst_tone", int'(toneOut), 0);
        checkOutput("midrst_playing", int'(playing), 0);
        checkOutput("midrst_curnote", int'(curNote), 0);
        resetN = 1'b1;
        @(negedge clk);
        checkOutput("midrst_restart_tone", int'(toneOut), 1);
        checkOutput("midrst_restart_curnote", int'(curNote), 1);
        measureRun(1'b1, len); checkOutput("midrst_table_restored", len, 5);

        applyStimulus(1'b0, 3'd1, 2'd0);
        measureRun(1'b0, len); checkOutput("final_low", len, 5);
        checkOutput("final_playing", int'(playing), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Parametrised square-wave tone generator for the FPGA piano: one runtime-programmable divider channel replaces a bank of fixed per-note dividers. It holds a writable table of half-period terminal counts, one per note, plus an octave shift and a gated start/stop. Frequency changes are glitch-free and the output always stops low on a full-period boundary. It sits between the keypad/note decoder and the speaker PWM/output pin.

## Interface
- NUM_NOTES, 8: number of table entries.
- SEL_WIDTH, 3: width of NOTE_SEL and CFG_ADDR; must satisfy 2^SEL_WIDTH ≥ NUM_NOTES.
- CNT_WIDTH, 19: width of counter and table entries.
- DEFAULT_TABLE, {95556,101238,113635,127550,143171,151684,170265,191109}: packed NUM_NOTES×CNT_WIDTH reset contents.
  - Entry 0 is in the LSBs, so entry 0 = 191109 (C4 at 100 MHz) and entry 7 = 95556 (C5).
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- NOTE_EN  in  1  gate; 1 = play.
- NOTE_SEL  in  SEL_WIDTH  table index to play.
- OCTAVE  in  2  octave up-shift, 0..3.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  SEL_WIDTH  table write index.
- CFG_DATA  in  CNT_WIDTH  table write value (terminal count).
- TONE_OUT  out  1  square wave.
- PLAYING  out  1  high whenever state ≠ IDLE.
- CUR_NOTE  out  SEL_WIDTH  index latched for the current half-period.

## Operation
- Table entry value T means half-period = T+1 clocks.
- Effective terminal: E = ((T+1) >> OCTAVE) − 1.
  - Compute with CNT_WIDTH+1 bits.
  - If (T+1) >> OCTAVE == 0, then E = 0 (one-clock half-period).
- NOTE_SEL ≥ NUM_NOTES selects entry NUM_NOTES−1.
- Table writes: on CFG_WE, entry CFG_ADDR ← CFG_DATA.
  - CFG_ADDR ≥ NUM_NOTES: write ignored.
  - Writes never disturb the running counter; a new value is used only when the next terminal is latched.
- FSM states IDLE, HIGH, LOW; registers cnt and term_q.
  - IDLE: cnt=0, TONE_OUT=0. If NOTE_EN=1: latch term_q=E, CUR_NOTE=NOTE_SEL (clamped), cnt←0, TONE_OUT←1, go HIGH.
  - HIGH: cnt increments. At cnt==term_q: cnt←0, TONE_OUT←0, relatch term_q/CUR_NOTE from current inputs, go LOW. NOTE_EN is ignored in HIGH; the high phase always completes.
  - LOW: cnt increments. At cnt==term_q: if NOTE_EN=1, cnt←0, TONE_OUT←1, relatch term_q/CUR_NOTE, go HIGH. Otherwise go IDLE with TONE_OUT staying 0.
- NOTE_SEL/OCTAVE changes mid-phase take effect only at the next toggle. There are no runt pulses.

## Timing
- Reset (RESET_N=0 at a clock edge) sets:
  - state=IDLE, cnt=0, term_q=0, TONE_OUT=0, PLAYING=0, CUR_NOTE=0.
  - Table ← DEFAULT_TABLE.
  - Reset mid-tone forces TONE_OUT low on that edge.
- Start latency: NOTE_EN sampled high in IDLE at edge k → TONE_OUT=1 and PLAYING=1 after edge k.
- Each phase lasts exactly term_q+1 cycles. Period = sum of the two latched phase lengths.
- Stop: NOTE_EN low → TONE_OUT ends low and PLAYING falls at the edge where the LOW phase terminal is reached.
  - The tone stops after at most one full period plus the remainder of the current phase.
  - If NOTE_EN re-rises before that edge, the tone continues seamlessly.
- Simultaneous CFG_WE to the selected entry at the relatch edge: the relatch uses the old table value; the new value applies at the following boundary.
- Counter never exceeds term_q. No wrap-around path exists.

## Test plan
- Reset defaults, CNT_WIDTH=19: NOTE_EN=1, NOTE_SEL=5, OCTAVE=0 → TONE_OUT high 113636 cycles, low 113636 cycles; CUR_NOTE=5.
- Small config (CNT_WIDTH=8, DEFAULT_TABLE entry0=2, entry1=4): play note 1 → TONE_OUT 5 high / 5 low. Switch to note 0 mid-high → that high phase still 5 cycles, then low 3 cycles.
- Octave: entry T=7, OCTAVE=0/1/2/3 → half-periods 8/4/2/1. Entry T=2 with OCTAVE=3 → half-period 1.
- Gate: NOTE_EN drops on the 2nd cycle of a 5-cycle high phase → high completes (5), low completes (5), then PLAYING=0. NOTE_EN re-asserted on the last LOW cycle → no gap.
- Config: write CFG_ADDR=1, CFG_DATA=9 while note 1 is playing → new 10-cycle phases start only after the next toggle. CFG_ADDR=NUM_NOTES write is ignored.
- Reset mid-high phase (RESET_N=0 for one edge) → TONE_OUT=0, PLAYING=0, table restored. With NOTE_EN=1 held, restart 1 cycle after reset release.
